// File: rtl/jtkcpu_intgen_pkg.sv
// Shared constants for the jtkcpu interrupt generator.
// Holds the CPU vector addresses, the register offsets of the
// 2-byte register window, and the NMI pulse state encoding.
package jtkcpu_intgen_pkg;

    // CPU vector addresses (high byte of each pair is at +1)
    localparam logic [15:0] VEC_FIRQ = 16'hFFF6;
    localparam logic [15:0] VEC_IRQ  = 16'hFFF8;
    localparam logic [15:0] VEC_NMI  = 16'hFFFC;

    // Register offsets selected by addr[0]
    localparam logic REG_EN   = 1'b0;
    localparam logic REG_PEND = 1'b1;

    typedef enum logic {
        NMI_IDLE,
        NMI_PULSE
    } nmi_state_t;

endpackage

// File: rtl/jtkcpu_intgen_line.sv
// One maskable interrupt line (IRQ or FIRQ) of the interrupt generator.
// Ports:
//   clk, rst, cen - clock, synchronous active-high reset, clock enable
//   src           - board event, rising-edge sensitive
//   en            - line enable from the CPU-writable enable register
//   clr           - clear request (W1C, enable cleared, vector fetch),
//                   already qualified with cen by the parent
//   pend          - pending latch, drives the active-low CPU input
module jtkcpu_intgen_line
    import jtkcpu_intgen_pkg::*;
#(
    parameter int IRQ_TO = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic cen,
    input  logic src,
    input  logic en,
    input  logic clr,
    output logic pend
);

    localparam logic [15:0] TO_LAST = 16'(IRQ_TO - 1);

    logic        src_q,  src_d;
    logic        pend_q, pend_d;
    logic [15:0] cnt_q,  cnt_d;
    logic        set;
    logic        timeout;

    assign set     = cen & en & src & ~src_q;
    assign timeout = (IRQ_TO > 0) && cen && pend_q && (cnt_q == TO_LAST);
    assign pend    = pend_q;

    always_comb begin
        src_d  = src_q;
        pend_d = pend_q;
        cnt_d  = cnt_q;
        if (cen) begin
            src_d = src;
            // A new event wins over every clear source on the same cycle
            if (set) begin
                pend_d = 1'b1;
            end else if (clr || timeout) begin
                pend_d = 1'b0;
            end
            // Count cen cycles spent pending; a fresh set restarts at 0
            if (IRQ_TO == 0 || set || !pend_q || timeout) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            src_q  <= 1'b0;
            pend_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            src_q  <= src_d;
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/jtkcpu_intgen.sv
// Interrupt generator driving the jtkcpu irq_n, firq_n and nmi_n inputs.
// Ports:
//   clk, rst, cen       - clock, synchronous active-high reset, clock enable
//   addr, rd, cs, wr    - CPU bus; rd+addr detect vector fetches, cs selects
//                         the 2-byte register window (addr[0] = offset)
//   din, dout           - register write data / registered read data
//   irq_src, firq_src,
//   nmi_src             - board events, rising-edge sensitive
//   irq_n, firq_n,
//   nmi_n               - active-low interrupt lines to the CPU
// Offset 0: enable {nmi, firq, irq}. Offset 1: pending, write-1-to-clear.
module jtkcpu_intgen
    import jtkcpu_intgen_pkg::*;
#(
    parameter int IRQ_TO = 0,
    parameter int NMI_W  = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cen,
    input  logic [15:0] addr,
    input  logic        rd,
    input  logic        cs,
    input  logic        wr,
    input  logic [7:0]  din,
    output logic [7:0]  dout,
    input  logic        irq_src,
    input  logic        firq_src,
    input  logic        nmi_src,
    output logic        irq_n,
    output logic        firq_n,
    output logic        nmi_n
);

    logic [2:0] en_q,      en_d;
    logic [7:0] dout_q,    dout_d;
    logic       nmi_src_q, nmi_src_d;
    logic [7:0] nmi_cnt_q, nmi_cnt_d;
    nmi_state_t nmi_state_q, nmi_state_d;

    logic reg_wr, reg_rd, wr_en, wr_clr;
    logic fetch_irq, fetch_firq, fetch_nmi;
    logic irq_clr, firq_clr, nmi_clr;
    logic irq_p, firq_p, nmi_active, nmi_edge;

    assign reg_wr = cen & cs & wr;
    assign reg_rd = cen & cs & ~wr;
    assign wr_en  = reg_wr & (addr[0] == REG_EN);
    assign wr_clr = reg_wr & (addr[0] == REG_PEND);

    // Vector fetch matches either byte of the two-byte vector
    assign fetch_irq  = rd & cen & (addr[15:1] == VEC_IRQ[15:1]);
    assign fetch_firq = rd & cen & (addr[15:1] == VEC_FIRQ[15:1]);
    assign fetch_nmi  = rd & cen & (addr[15:1] == VEC_NMI[15:1]);

    assign irq_clr  = (wr_clr & din[0]) | (wr_en & ~din[0]) | fetch_irq;
    assign firq_clr = (wr_clr & din[1]) | (wr_en & ~din[1]) | fetch_firq;
    // Disabling en[2] deliberately does not cut an NMI pulse in progress
    assign nmi_clr  = (wr_clr & din[2]) | fetch_nmi;

    jtkcpu_intgen_line #(.IRQ_TO(IRQ_TO)) u_irq (
        .clk  (clk),
        .rst  (rst),
        .cen  (cen),
        .src  (irq_src),
        .en   (en_q[0]),
        .clr  (irq_clr),
        .pend (irq_p)
    );

    jtkcpu_intgen_line #(.IRQ_TO(IRQ_TO)) u_firq (
        .clk  (clk),
        .rst  (rst),
        .cen  (cen),
        .src  (firq_src),
        .en   (en_q[1]),
        .clr  (firq_clr),
        .pend (firq_p)
    );

    assign nmi_edge   = nmi_src & ~nmi_src_q;
    assign nmi_active = (nmi_state_q == NMI_PULSE);

    assign irq_n  = ~irq_p;
    assign firq_n = ~firq_p;
    assign nmi_n  = ~nmi_active;
    assign dout   = dout_q;

    always_comb begin
        en_d      = en_q;
        dout_d    = dout_q;
        nmi_src_d = nmi_src_q;
        if (cen) begin
            nmi_src_d = nmi_src;
        end
        if (wr_en) begin
            en_d = din[2:0];
        end
        if (reg_rd) begin
            dout_d = (addr[0] == REG_PEND) ? {5'b0, nmi_active, firq_p, irq_p}
                                           : {5'b0, en_q};
        end
    end

    always_comb begin
        nmi_state_d = nmi_state_q;
        nmi_cnt_d   = nmi_cnt_q;
        case (nmi_state_q)
            NMI_IDLE: begin
                if (cen && nmi_edge && en_q[2]) begin
                    nmi_state_d = NMI_PULSE;
                    nmi_cnt_d   = 8'(NMI_W);
                end
            end
            NMI_PULSE: begin
                // Further NMI edges are ignored; the pulse never restarts
                if (cen) begin
                    if (nmi_cnt_q == 8'd1 || nmi_clr) begin
                        nmi_state_d = NMI_IDLE;
                        nmi_cnt_d   = '0;
                    end else begin
                        nmi_cnt_d = nmi_cnt_q - 8'd1;
                    end
                end
            end
            default: begin
                nmi_state_d = NMI_IDLE;
                nmi_cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            en_q        <= '0;
            dout_q      <= '0;
            nmi_src_q   <= 1'b0;
            nmi_cnt_q   <= '0;
            nmi_state_q <= NMI_IDLE;
        end else begin
            en_q        <= en_d;
            dout_q      <= dout_d;
            nmi_src_q   <= nmi_src_d;
            nmi_cnt_q   <= nmi_cnt_d;
            nmi_state_q <= nmi_state_d;
        end
    end

endmodule

// File: doc/jtkcpu_intgen.md
Name: jtkcpu_intgen

Overview:
Peripheral-side interrupt generator that drives the CPU's irq_n, firq_n and nmi_n inputs. It latches board interrupt events (vblank, timers, sound latch), gates them with a CPU-writable enable register, and releases each line when the CPU fetches the matching vector or clears it by register write. An optional timeout also releases a line. Sits between board event sources and the jtkcpu core, on the CPU data bus as a 2-byte memory-mapped device.

Parameters:
IRQ_TO, 0, cen-cycles before a pending IRQ/FIRQ auto-clears; 0 disables the timeout.
NMI_W, 32, nmi_n low-pulse width in cen-cycles (1..255).

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active high
cen  in  1  clock enable; all state advances only when cen=1
addr  in  16  CPU address bus
rd  in  1  CPU read strobe, used for vector-fetch detection
cs  in  1  register chip select (decoded externally)
wr  in  1  CPU write strobe
din  in  8  CPU write data
dout  out  8  register read data
irq_src  in  1  IRQ event, rising-edge sensitive
firq_src  in  1  FIRQ event, rising-edge sensitive
nmi_src  in  1  NMI event, rising-edge sensitive
irq_n  out  1  to CPU irq_n, active low
firq_n  out  1  to CPU firq_n, active low
nmi_n  out  1  to CPU nmi_n, active low

Behaviour:
- Clocking and reset: one clock, clk. rst is synchronous and active-high.
- Reset state: en=3'b000, pending=0, NMI counter=0, edge samples=0, timeout counters=0, irq_n=firq_n=nmi_n=1, dout=0.
- Edge detection: each src is registered on cen cycles. edge = src & ~src_q.
- Register map, when cs=1:
  - addr[0]=0: write sets en[2:0] = {nmi, firq, irq}. Read returns {5'b0, en}.
  - addr[0]=1: write is write-1-to-clear of pending {nmi_active, firq_p, irq_p}. Read returns {5'b0, nmi_active, firq_p, irq_p}.
- dout is registered. It updates on the cen cycle where cs & ~wr, and holds otherwise.
- IRQ/FIRQ latches:
  - Set on edge when the matching en bit is 1.
  - Cleared by any of: W1C write; en bit written 0; vector fetch; timeout.
  - Vector fetch = rd & cen & addr in {FFF8, FFF9} for IRQ, or {FFF6, FFF7} for FIRQ.
  - Priority: a set on the same cycle as any clear wins, so the latch stays pending.
- Line outputs: irq_n = ~irq_p and firq_n = ~firq_p, taken straight from flops. Latency from the src-rising cen cycle to line low is 1 clk.
- NMI state machine:
  - IDLE: on edge & en[2], load counter with NMI_W, drive nmi_n=0, go to PULSE.
  - PULSE: decrement the counter each cen cycle. Return to IDLE (nmi_n=1) when the counter reaches 1, or on vector fetch {FFFC, FFFD}, or on W1C bit2.
  - An NMI edge during PULSE is ignored; nmi_n stays low and the counter does not restart.
  - Writing en[2]=0 does not cut a pulse already in progress.
- Timeout, only when IRQ_TO>0:
  - Per-line 16-bit counter. Reset to 0 when the line is not pending; increments on cen while pending.
  - When the count equals IRQ_TO-1, the latch clears on that cycle.
  - A set on the same cycle restarts the count at 0.
- cen=0: no state changes, no edge sampling, and reads/writes are ignored.
- rst mid-operation: all lines deassert on the next clk; a pending event is lost.

Decomposition:
- Shared package: vector addresses VEC_FIRQ=16'hFFF6, VEC_IRQ=16'hFFF8, VEC_NMI=16'hFFFC, plus register offsets. Place them in the existing include file next to the CPU opcode constants, so CPU and generator agree.
- One natural sub-module: jtkcpu_intgen_line. It contains edge detect, pending latch, timeout counter and clear logic, and is instantiated twice (IRQ, FIRQ).
- NMI pulse logic stays in the top.

Test Plan:
- Reset, write en=3'b001, pulse irq_src -> irq_n low 1 clk later. CPU read of FFF8 with rd=1 -> irq_n high next clk. Pending register reads 0.
- en=0, pulse firq_src -> firq_n stays 1. Set en=3'b010, pulse again -> firq_n low. W1C write 8'h02 to offset 1 -> firq_n high.
- NMI_W=4, en[2]=1, nmi_src rises -> nmi_n low for exactly 4 cen cycles. A second edge at cycle 2 does not extend the pulse.
- IRQ_TO=10, en irq, pulse irq_src with no acknowledge -> irq_n low for exactly 10 cen cycles, then high.
- Simultaneous irq edge and FFF8 fetch on the same cen cycle -> irq_n remains low. Also toggle cen=0 for 3 cycles mid-pulse -> NMI width extends by 3 clk.
- Assert rst while irq_n, firq_n and nmi_n are all low -> all three high next clk. en and dout read back 0.
